// File: rtl/kdiv_pkg.sv
// Shared constants and types for the 128/64 sequential divider.
// Provides widths, FSM state encoding and the saturated quotient value.
package kdiv_pkg;

   localparam int DW = 64;
   localparam int CW = 7;

   localparam logic [CW-1:0] LAST  = CW'(DW - 1);
   localparam logic [DW-1:0] QONES = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/kdiv128_seq_if.sv
// Request/result bundle of kdiv128_seq.
// master: issues start/dividend/divisor; slave: returns busy/done/results.
interface kdiv128_seq_if;
   import kdiv_pkg::*;

   logic                start;
   logic [2*DW-1:0]     dividend;
   logic [DW-1:0]       divisor;
   logic                busy;
   logic                done;
   logic [DW-1:0]       quotient;
   logic [DW-1:0]       remainder;
   logic                div_zero;
   logic                ovf;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero, ovf
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero, ovf
   );

endinterface

// File: rtl/kdiv_step.sv
// One radix-2 restoring division iteration (combinational).
// Ports: r/q/d current partial remainder, quotient shift reg, divisor; r_nxt/q_nxt.
module kdiv_step
   import kdiv_pkg::*;
(
   input  logic [DW-1:0] r,
   input  logic [DW-1:0] q,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] r_nxt,
   output logic [DW-1:0] q_nxt
);

   logic [DW:0]   t;
   logic [DW-1:0] diff;
   logic          ge;

   // 65-bit shifted remainder keeps the MSB that falls out of r
   assign t    = {r, q[DW-1]};
   assign ge   = t >= {1'b0, d};
   // t - d < d whenever ge holds, so the low DW bits are exact
   assign diff = t[DW-1:0] - d;

   assign r_nxt = ge ? diff : t[DW-1:0];
   assign q_nxt = {q[DW-2:0], ge};

endmodule

// File: rtl/kdiv128_seq.sv
// Sequential restoring divider: 128-bit dividend / 64-bit divisor, 1 bit/clk.
// Ports: clk, rst_n (sync, active-low), io (slave: start/dividend/divisor in,
// busy/done/quotient/remainder/div_zero/ovf out). Optional KDIV_OVF_CHECK_EN
// flags quotients that cannot fit in 64 bits instead of iterating.
module kdiv128_seq
   import kdiv_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   kdiv128_seq_if.slave  io
);

   state_t        st;
   logic [CW-1:0] cnt;
   // Partial remainder kept at DW bits: with hi < d it never exceeds d-1
   logic [DW-1:0] r;
   logic [DW-1:0] q;
   logic [DW-1:0] d;
   logic [DW-1:0] r_nxt;
   logic [DW-1:0] q_nxt;

   logic          busy_q;
   logic          done_q;
   logic          dz_q;
   logic [DW-1:0] quo_q;
   logic [DW-1:0] rem_q;

   logic [DW-1:0] hi;
   logic [DW-1:0] lo;

   assign hi = io.dividend[2*DW-1:DW];
   assign lo = io.dividend[DW-1:0];

`ifdef KDIV_OVF_CHECK_EN
   logic ovf_q;
   logic too_big;
   assign too_big = hi >= io.divisor;
   assign io.ovf  = ovf_q;
`else
   assign io.ovf  = 1'b0;
`endif

   kdiv_step u_step (
      .r     (r),
      .q     (q),
      .d     (d),
      .r_nxt (r_nxt),
      .q_nxt (q_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st     <= IDLE;
         cnt    <= '0;
         r      <= '0;
         q      <= '0;
         d      <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         quo_q  <= '0;
         rem_q  <= '0;
`ifdef KDIV_OVF_CHECK_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (st)
            RUN: begin
               r   <= r_nxt;
               q   <= q_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  st     <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  quo_q  <= q_nxt;
                  rem_q  <= r_nxt;
               end
            end
            default: begin
               // IDLE and DONE both accept, giving back-to-back issue
               st <= IDLE;
               if (io.start) begin
                  r    <= hi;
                  q    <= lo;
                  d    <= io.divisor;
                  cnt  <= '0;
                  dz_q <= 1'b0;
`ifdef KDIV_OVF_CHECK_EN
                  ovf_q <= 1'b0;
`endif
                  if (io.divisor == '0) begin
                     st     <= DONE;
                     done_q <= 1'b1;
                     dz_q   <= 1'b1;
                     quo_q  <= QONES;
                     rem_q  <= lo;
                  end
`ifdef KDIV_OVF_CHECK_EN
                  else if (too_big) begin
                     st     <= DONE;
                     done_q <= 1'b1;
                     ovf_q  <= 1'b1;
                     quo_q  <= QONES;
                     rem_q  <= '0;
                  end
`endif
                  else begin
                     st     <= RUN;
                     busy_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign io.busy      = busy_q;
   assign io.done      = done_q;
   assign io.div_zero  = dz_q;
   assign io.quotient  = quo_q;
   assign io.remainder = rem_q;

endmodule
